// File: rtl/decode_stage.sv
// decode_stage
//   One-entry decode pipeline stage. Splits a 16-bit instruction into register
//   selects and control strobes and holds the decoded word in output registers
//   under a valid/ready handshake. After a status-writing word leaves the stage,
//   one bubble cycle (WAIT_STAT) is inserted. This lets a following conditional
//   branch sample the updated status.
//
//   Instruction fields: opcode [15:11], op1 [9 -: SEL_WIDTH],
//   op2 [4 -: SEL_WIDTH], literal [DATA_WIDTH-1:0]. The literal overlaps op2,
//   and each opcode uses only the fields it needs.
//
//   Opcode map: NOP 00, ADD 01, ADDC 02, SUB 03, SUBU 04, AND 05, OR 06, XOR 07,
//   NOT 08, SHL 09, SHR 0A, VAL 0B, CMP 0C, GOTO 10, IFZ 11, IFNZ 12, IFEQ 13,
//   IFST 14, IFGT 15. Opcodes 0D-0F and 16-1F are reserved.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_instr/in_valid/in_ready   upstream handshake
//     status                current status register (bit 0 C, 1 underflow,
//                           2 Z, 3 EQ, 4 GT, 5 ST)
//     out_valid/out_ready   downstream handshake
//     opcode, literal_adr, rd_sel1, rd_sel2, wr_sel   registered fields
//     rd_en1, rd_en2, wr_en, sel_alu, stat_wr_en, cnt_wr_en, add_offset
//                           registered control strobes
//     illegal               registered reserved-opcode flag
//
//   Build option: DECODE_STAGE_IFGT_EN enables IFGT (0x15) to branch on the GT
//   bit. Without this option, 0x15 decodes as an illegal NOP.
module decode_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 2,
    parameter int STAT_BITS  = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           in_instr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [STAT_BITS-1:0]  status,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            opcode,
    output logic [DATA_WIDTH-1:0] literal_adr,
    output logic [SEL_WIDTH-1:0]  rd_sel1,
    output logic [SEL_WIDTH-1:0]  rd_sel2,
    output logic [SEL_WIDTH-1:0]  wr_sel,
    output logic                  rd_en1,
    output logic                  rd_en2,
    output logic                  wr_en,
    output logic                  sel_alu,
    output logic                  stat_wr_en,
    output logic                  cnt_wr_en,
    output logic                  add_offset,
    output logic                  illegal
);

    localparam logic [4:0] OP_NOP  = 5'h00, OP_ADD  = 5'h01, OP_ADDC = 5'h02,
                           OP_SUB  = 5'h03, OP_SUBU = 5'h04, OP_AND  = 5'h05,
                           OP_OR   = 5'h06, OP_XOR  = 5'h07, OP_NOT  = 5'h08,
                           OP_SHL  = 5'h09, OP_SHR  = 5'h0A, OP_VAL  = 5'h0B,
                           OP_CMP  = 5'h0C, OP_GOTO = 5'h10, OP_IFZ  = 5'h11,
                           OP_IFNZ = 5'h12, OP_IFEQ = 5'h13, OP_IFST = 5'h14,
                           OP_IFGT = 5'h15;

    localparam int ST_ZERO = 2, ST_EQ = 3, ST_GT = 4, ST_ST = 5;

    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_WAIT_STAT} state_t;

    typedef struct packed {
        logic [4:0]            opcode;
        logic [DATA_WIDTH-1:0] literal;
        logic [SEL_WIDTH-1:0]  rd_sel1;
        logic [SEL_WIDTH-1:0]  rd_sel2;
        logic [SEL_WIDTH-1:0]  wr_sel;
        logic                  rd_en1;
        logic                  rd_en2;
        logic                  wr_en;
        logic                  sel_alu;
        logic                  stat_wr_en;
        logic                  cnt_wr_en;
        logic                  add_offset;
        logic                  illegal;
    } word_t;

    state_t state_q, state_d;
    word_t  word_q, word_d, dec;
    logic   load;

    logic [4:0]           in_opc;
    logic [SEL_WIDTH-1:0] op1, op2;

    assign in_opc = in_instr[15:11];
    assign op1    = in_instr[9 -: SEL_WIDTH];
    assign op2    = in_instr[4 -: SEL_WIDTH];

    // Some instruction and status bits are ignored by design.
    logic unused_bits;
    assign unused_bits = ^{in_instr, status};

    // Combinational decode of the incoming instruction.
    always_comb begin
        dec         = '0;
        dec.opcode  = in_opc;
        dec.literal = in_instr[DATA_WIDTH-1:0];
        case (in_opc)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR: begin
                dec.rd_sel1    = op1;
                dec.wr_sel     = op1;
                dec.rd_sel2    = op2;
                dec.rd_en1     = 1'b1;
                dec.rd_en2     = 1'b1;
                dec.wr_en      = 1'b1;
                dec.sel_alu    = 1'b1;
                dec.stat_wr_en = 1'b1;
            end
            OP_NOT: begin
                dec.rd_sel2    = op2;
                dec.wr_sel     = op1;
                dec.rd_en2     = 1'b1;
                dec.wr_en      = 1'b1;
                dec.sel_alu    = 1'b1;
                dec.stat_wr_en = 1'b1;
            end
            OP_SHL, OP_SHR: begin
                dec.rd_sel1    = op1;
                dec.wr_sel     = op1;
                dec.rd_en1     = 1'b1;
                dec.wr_en      = 1'b1;
                dec.sel_alu    = 1'b1;
                dec.stat_wr_en = 1'b1;
            end
            OP_VAL: begin
                dec.wr_sel = op1;
                dec.wr_en  = 1'b1;
            end
            OP_CMP: begin
                dec.rd_sel1    = op1;
                dec.rd_sel2    = op2;
                dec.rd_en1     = 1'b1;
                dec.rd_en2     = 1'b1;
                dec.stat_wr_en = 1'b1;
            end
            OP_GOTO: dec.cnt_wr_en = 1'b1;
            OP_IFZ: begin
                dec.cnt_wr_en  = status[ST_ZERO];
                dec.add_offset = status[ST_ZERO];
            end
            OP_IFNZ: begin
                dec.cnt_wr_en  = ~status[ST_ZERO];
                dec.add_offset = ~status[ST_ZERO];
            end
            OP_IFEQ: begin
                dec.cnt_wr_en  = status[ST_EQ];
                dec.add_offset = status[ST_EQ];
            end
            OP_IFST: begin
                dec.cnt_wr_en  = status[ST_ST];
                dec.add_offset = status[ST_ST];
            end
            OP_IFGT: begin
`ifdef DECODE_STAGE_IFGT_EN
                dec.cnt_wr_en  = status[ST_GT];
                dec.add_offset = status[ST_GT];
`else
                dec.illegal    = 1'b1;
`endif
            end
            5'h0D, 5'h0E, 5'h0F, 5'h16, 5'h17, 5'h18, 5'h19, 5'h1A,
            5'h1B, 5'h1C, 5'h1D, 5'h1E, 5'h1F: dec.illegal = 1'b1;
            default: ; // NOP: everything stays 0
        endcase
    end

    // Handshake FSM. A status-writing word that leaves the stage blocks
    // acceptance for that cycle and the following WAIT_STAT cycle.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            S_EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (out_ready) begin
                    if (word_q.stat_wr_en) begin
                        state_d = S_WAIT_STAT;
                    end else begin
                        in_ready = 1'b1;
                        if (in_valid) load = 1'b1;
                        else          state_d = S_EMPTY;
                    end
                end
            end
            S_WAIT_STAT: state_d = S_EMPTY;
            default:     state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        word_d = word_q;
        if (load) word_d = dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    assign out_valid   = (state_q == S_FULL);
    assign opcode      = word_q.opcode;
    assign literal_adr = word_q.literal;
    assign rd_sel1     = word_q.rd_sel1;
    assign rd_sel2     = word_q.rd_sel2;
    assign wr_sel      = word_q.wr_sel;
    assign rd_en1      = word_q.rd_en1;
    assign rd_en2      = word_q.rd_en2;
    assign wr_en       = word_q.wr_en;
    assign sel_alu     = word_q.sel_alu;
    assign stat_wr_en  = word_q.stat_wr_en;
    assign cnt_wr_en   = word_q.cnt_wr_en;
    assign add_offset  = word_q.add_offset;
    assign illegal     = word_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage. The stimulus pushes a hand-computed
// expected decoded word for each accepted instruction. The monitor pops an
// expected word and compares it at every output transfer.
// The expected word layout is {opcode, literal, rd_sel1, rd_sel2, wr_sel,
// rd_en1, rd_en2, wr_en, sel_alu, stat_wr_en, cnt_wr_en, add_offset, illegal}.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  status;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  opcode;
    logic [7:0]  literal_adr;
    logic [1:0]  rd_sel1, rd_sel2, wr_sel;
    logic        rd_en1, rd_en2, wr_en, sel_alu, stat_wr_en, cnt_wr_en, add_offset;
    logic        illegal;

    int tests = 0;
    int fails = 0;
    logic [26:0] sb[$];
    string       sb_name[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready), .status(status), .out_valid(out_valid),
        .out_ready(out_ready), .opcode(opcode), .literal_adr(literal_adr),
        .rd_sel1(rd_sel1), .rd_sel2(rd_sel2), .wr_sel(wr_sel),
        .rd_en1(rd_en1), .rd_en2(rd_en2), .wr_en(wr_en), .sel_alu(sel_alu),
        .stat_wr_en(stat_wr_en), .cnt_wr_en(cnt_wr_en), .add_offset(add_offset),
        .illegal(illegal)
    );

    function automatic logic [26:0] ew(input logic [4:0] op, input logic [7:0] lit,
                                       input logic [1:0] s1, input logic [1:0] s2,
                                       input logic [1:0] ws, input logic [7:0] f);
        return {op, lit, s1, s2, ws, f};
    endfunction

    function automatic logic [26:0] act_word();
        return {opcode, literal_adr, rd_sel1, rd_sel2, wr_sel, rd_en1, rd_en2,
                wr_en, sel_alu, stat_wr_en, cnt_wr_en, add_offset, illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Present an instruction until accepted, then record its expected word.
    task automatic send(input string nm, input logic [15:0] ins,
                        input logic [5:0] st, input logic [26:0] exp);
        status   = st;
        in_instr = ins;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                sb_name.push_back(nm);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        tests++;
        fails++;
        $display("FAIL %s: not accepted within 20 cycles, in_ready=%0b expected 1", nm, in_ready);
        in_valid = 1'b0;
    endtask

    // Monitor: an output transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: got word 0x%0h expected no output", act_word());
            end else begin
                logic [26:0] e;
                string nm;
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                if (act_word() !== e) begin
                    fails++;
                    $display("FAIL %s: got word 0x%07h expected 0x%07h", nm, act_word(), e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_instr = '0; in_valid = 1'b0; status = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_word", act_word(), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        send("add_r1_r2",  16'h0910, 6'b000000, ew(5'h01, 8'h10, 2'd1, 2'd2, 2'd1, 8'b1111_1000));
        send("ifz_taken",  16'h8805, 6'b000100, ew(5'h11, 8'h05, 2'd0, 2'd0, 2'd0, 8'b0000_0110));
        send("ifz_not",    16'h8805, 6'b000000, ew(5'h11, 8'h05, 2'd0, 2'd0, 2'd0, 8'b0000_0000));
        send("not_r3_r1",  16'h4308, 6'b000000, ew(5'h08, 8'h08, 2'd0, 2'd1, 2'd3, 8'b0111_1000));
        send("shl_r2",     16'h4A18, 6'b000000, ew(5'h09, 8'h18, 2'd2, 2'd0, 2'd2, 8'b1011_1000));
        send("nop",        16'h0312, 6'b000000, ew(5'h00, 8'h12, 2'd0, 2'd0, 2'd0, 8'b0000_0000));
        send("ifnz_taken", 16'h9007, 6'b000000, ew(5'h12, 8'h07, 2'd0, 2'd0, 2'd0, 8'b0000_0110));
        send("ifst_taken", 16'hA009, 6'b100000, ew(5'h14, 8'h09, 2'd0, 2'd0, 2'd0, 8'b0000_0110));
        send("ifst_not",   16'hA009, 6'b011111, ew(5'h14, 8'h09, 2'd0, 2'd0, 2'd0, 8'b0000_0000));
        send("rsv_0e",     16'h7355, 6'b000000, ew(5'h0E, 8'h55, 2'd0, 2'd0, 2'd0, 8'b0000_0001));
        send("rsv_1f",     16'hF8FF, 6'b111111, ew(5'h1F, 8'hFF, 2'd0, 2'd0, 2'd0, 8'b0000_0001));
`ifdef DECODE_STAGE_IFGT_EN
        send("ifgt",       16'hA842, 6'b010000, ew(5'h15, 8'h42, 2'd0, 2'd0, 2'd0, 8'b0000_0110));
`else
        send("ifgt",       16'hA842, 6'b010000, ew(5'h15, 8'h42, 2'd0, 2'd0, 2'd0, 8'b0000_0001));
`endif

        // CMP leaves, one bubble follows, and IFEQ sees the status written meanwhile.
        send("cmp_r2_r1",  16'h6208, 6'b000000, ew(5'h0C, 8'h08, 2'd2, 2'd1, 2'd0, 8'b1100_1000));
        @(negedge clk);
        @(posedge clk); #1;
        status = 6'b001000; in_instr = 16'h9820; in_valid = 1'b1;
        @(negedge clk);
        chk("wait_in_ready", in_ready, 0);
        chk("wait_out_valid", out_valid, 0);
        send("ifeq_after_cmp", 16'h9820, 6'b001000, ew(5'h13, 8'h20, 2'd0, 2'd0, 2'd0, 8'b0000_0110));
        @(negedge clk);
        @(posedge clk); #1;

        // Back-pressure: hold VAL for 3 cycles, then swap in GOTO in the same cycle.
        out_ready = 1'b0;
        send("val_r1", 16'h59A5, 6'b000000, ew(5'h0B, 8'hA5, 2'd0, 2'd0, 2'd1, 8'b0010_0000));
        in_instr = 16'h803C; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_word", act_word(), ew(5'h0B, 8'hA5, 2'd0, 2'd0, 2'd1, 8'b0010_0000));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send("goto", 16'h803C, 6'b000000, ew(5'h10, 8'h3C, 2'd0, 2'd0, 2'd0, 8'b0000_0100));
        @(negedge clk);
        @(posedge clk); #1;

        // Asynchronous reset while FULL discards the held word.
        out_ready = 1'b0;
        send("val_rst", 16'h59A5, 6'b000000, ew(5'h0B, 8'hA5, 2'd0, 2'd0, 2'd1, 8'b0010_0000));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_wr_en", wr_en, 0);
        chk("async_rst_word", act_word(), 0);
        sb.delete();
        sb_name.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send("post_rst_add", 16'h0910, 6'b000000, ew(5'h01, 8'h10, 2'd1, 2'd2, 2'd1, 8'b1111_1000));

        repeat (10) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
